// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle MIPS-subset datapath.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Fetch and data-memory
// handshakes can stall it. A syscall, an illegal instruction or a
// data-memory timeout parks it in HALT. Only reset leaves HALT.
//
// Ports:
//   clk, rst_b          clock, async active-low reset
//   inst, inst_valid    fetched instruction word and its handshake
//   mem_ready           data-memory handshake completion
//   alu_zero            ALU zero flag (beq resolution)
//   inst_req            fetch request
//   mem_req, mem_we     data-memory request / write qualifier
//   regDest, aluSrc, memOrReg, write_enable   datapath selects, RF write
//   alu_operation       0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 XOR,6 NOR
//   pc_en, pc_sel       PC strobe; 0 PC+4, 1 branch, 2 jump
//   halted, fault       sticky halt / fault flags
//
// Optional macro MULTICYCLE_PERF_EN adds cycle_cnt (non-HALT cycles) and
// instret_cnt (pc_en pulses).
module multicycle_ctrl #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [XLEN-1:0] inst,
    input  logic            inst_valid,
    input  logic            mem_ready,
    input  logic            alu_zero,
    output logic            inst_req,
    output logic            mem_req,
    output logic            mem_we,
    output logic            regDest,
    output logic            aluSrc,
    output logic            memOrReg,
    output logic            write_enable,
    output logic [3:0]      alu_operation,
    output logic            pc_en,
    output logic [1:0]      pc_sel,
    output logic            halted,
    output logic            fault
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt
`endif
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t         state, state_nxt;
    // Only the opcode and funct fields of the IR steer control.
    logic [5:0]     ir_op, ir_fn;
    logic [WCW-1:0] wait_cnt;

    logic           unused_inst;
    assign unused_inst = ^inst;

    logic       is_r, is_sys, is_addi, is_lw, is_sw, is_beq, is_j, legal;
    logic [3:0] r_alu, ex_alu;
    logic       mem_timeout;

    always_comb begin
        r_alu = ALU_ADD;
        is_r  = 1'b1;
        case (ir_fn)
            6'h20:   r_alu = 4'd0;
            6'h22:   r_alu = 4'd1;
            6'h24:   r_alu = 4'd2;
            6'h25:   r_alu = 4'd3;
            6'h2A:   r_alu = 4'd4;
            6'h26:   r_alu = 4'd5;
            6'h27:   r_alu = 4'd6;
            default: is_r  = 1'b0;
        endcase
        is_r    = is_r && (ir_op == OP_RTYPE);
        is_sys  = (ir_op == OP_RTYPE) && (ir_fn == FN_SYSCALL);
        is_addi = (ir_op == OP_ADDI);
        is_lw   = (ir_op == OP_LW);
        is_sw   = (ir_op == OP_SW);
        is_beq  = (ir_op == OP_BEQ);
        is_j    = (ir_op == OP_J);
        legal   = is_r || is_sys || is_addi || is_lw || is_sw || is_beq || is_j;
        ex_alu  = is_beq ? ALU_SUB : (is_r ? r_alu : ALU_ADD);
    end

    // Fires on the MEM_TIMEOUT-th stalled cycle. A mem_ready in that same
    // cycle still completes the access.
    assign mem_timeout = (state == S_MEM) && !mem_ready &&
                         (wait_cnt == WCW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= S_FETCH;
            ir_op    <= '0;
            ir_fn    <= '0;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && inst_valid) begin
                ir_op <= inst[31:26];
                ir_fn <= inst[5:0];
            end
            wait_cnt <= (state == S_MEM && !mem_ready) ? wait_cnt + 1'b1 : '0;
            if ((state == S_DECODE && !legal) || mem_timeout)
                fault <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        inst_req      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        regDest       = 1'b0;
        aluSrc        = 1'b0;
        memOrReg      = 1'b0;
        write_enable  = 1'b0;
        alu_operation = ALU_ADD;
        pc_en         = 1'b0;
        pc_sel        = 2'd0;
        halted        = 1'b0;
        case (state)
            S_FETCH: begin
                // Gated by rst_b so the request is low while reset is held.
                inst_req = rst_b;
                if (inst_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = (is_sys || !legal) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alu_operation = ex_alu;
                regDest       = is_r;
                aluSrc        = is_addi || is_lw || is_sw;
                if (is_r || is_addi)     state_nxt = S_WB;
                else if (is_lw || is_sw) state_nxt = S_MEM;
                else                     state_nxt = S_FETCH;
                if (is_beq) begin
                    pc_en  = 1'b1;
                    pc_sel = alu_zero ? 2'd1 : 2'd0;
                end else if (is_j) begin
                    pc_en  = 1'b1;
                    pc_sel = 2'd2;
                end
            end
            S_MEM: begin
                mem_req       = 1'b1;
                mem_we        = is_sw;
                aluSrc        = 1'b1;
                memOrReg      = is_lw;
                alu_operation = ALU_ADD;
                // sw retires on the transition out of MEM.
                pc_en         = is_sw && mem_ready;
                if (mem_ready)        state_nxt = is_lw ? S_WB : S_FETCH;
                else if (mem_timeout) state_nxt = S_HALT;
            end
            S_WB: begin
                write_enable  = 1'b1;
                regDest       = is_r;
                aluSrc        = !is_r;
                memOrReg      = is_lw;
                alu_operation = ex_alu;
                pc_en         = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = S_HALT;
        endcase
    end

`ifdef MULTICYCLE_PERF_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_HALT) cycle_cnt   <= cycle_cnt + 32'd1;
            if (pc_en)           instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. It has a directed vector table, hand-written
// reset sequences and a set of random instructions. The random ones are
// compared against an instruction-level reference model.
module tb_multicycle_ctrl;
    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic [31:0] inst = '0;
    logic        inst_valid = 1'b0, mem_ready = 1'b0, alu_zero = 1'b0;
    logic        inst_req, mem_req, mem_we, regDest, aluSrc, memOrReg;
    logic        write_enable, pc_en, halted, fault;
    logic [3:0]  alu_operation;
    logic [1:0]  pc_sel;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_ctrl #(.XLEN(32), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst_b(rst_b), .inst(inst), .inst_valid(inst_valid),
        .mem_ready(mem_ready), .alu_zero(alu_zero), .inst_req(inst_req),
        .mem_req(mem_req), .mem_we(mem_we), .regDest(regDest), .aluSrc(aluSrc),
        .memOrReg(memOrReg), .write_enable(write_enable),
        .alu_operation(alu_operation), .pc_en(pc_en), .pc_sel(pc_sel),
        .halted(halted), .fault(fault)
`ifdef MULTICYCLE_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Per-instruction summary: counts of each event plus the selects seen
    // in EXEC (aluSrc, alu op) and in WB (regDest, memOrReg).
    typedef struct {
        int cycles, we, we_cyc, pc, sel, memc, memwe, rd, as_, mr, alu;
        bit chk_ex;
        int halted, fault;
    } res_t;

    typedef struct {
        logic [31:0] inst;
        int fw, mw;
        bit z;
        int cycles, we, sel, memc, halted, fault;
    } vec_t;

    vec_t tbl[11];
    int   checks = 0, failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: fw = fetch stall cycles, mw = mem stall cycles before
    // mem_ready, z = alu_zero. EXEC is cycle fw+3.
    function automatic res_t model(input logic [31:0] i, input int fw, input int mw, input bit z);
        res_t r = '{default: 0};
        logic [5:0] op = i[31:26];
        logic [5:0] fn = i[5:0];
        int ex = fw + 3;
        if (op == 6'h00 && fn == 6'h0C) begin
            r.cycles = ex; r.halted = 1;
        end else if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A}) begin
            r.cycles = ex + 1; r.we = 1; r.pc = 1; r.rd = 1; r.chk_ex = 1;
            case (fn)
                6'h20: r.alu = 0;  6'h22: r.alu = 1;  6'h24: r.alu = 2;
                6'h25: r.alu = 3;  6'h2A: r.alu = 4;  6'h26: r.alu = 5;
                default: r.alu = 6;
            endcase
        end else if (op == 6'h08) begin
            r.cycles = ex + 1; r.we = 1; r.pc = 1; r.as_ = 1; r.chk_ex = 1;
        end else if (op == 6'h23 || op == 6'h2B) begin
            r.as_ = 1; r.chk_ex = 1;
            if (mw >= T) begin
                r.memc = T; r.cycles = ex + T + 1; r.halted = 1; r.fault = 1;
            end else begin
                r.memc = mw + 1; r.pc = 1;
                if (op == 6'h23) begin r.cycles = ex + mw + 2; r.we = 1; r.mr = 1; end
                else r.cycles = ex + mw + 1;
            end
            if (op == 6'h2B) r.memwe = r.memc;
        end else if (op == 6'h04) begin
            r.cycles = ex; r.pc = 1; r.sel = z ? 1 : 0; r.alu = 1; r.chk_ex = 1;
        end else if (op == 6'h02) begin
            r.cycles = ex; r.pc = 1; r.sel = 2;
        end else begin
            r.cycles = ex; r.halted = 1; r.fault = 1;
        end
        r.we_cyc = r.we != 0 ? r.cycles : 0;
        return r;
    endfunction

    // Entered and left at posedge+1 with the DUT in FETCH (or HALT on exit).
    task automatic run(input logic [31:0] i, input int fw, input int mw, input bit z, output res_t o);
        int fc = 0, mc = 0, cyc = 0;
        bit done = 0;
        o = '{default: 0};
        inst = i; alu_zero = z;
        while (!done && cyc < 60) begin
            inst_valid = inst_req && (fc == fw);
            mem_ready  = mem_req && (mc == mw);
            @(negedge clk);
            cyc++;
            if (inst_req) fc++;
            if (mem_req) begin mc++; o.memc++; if (mem_we) o.memwe++; end
            if (cyc == fw + 3) begin o.as_ = aluSrc; o.alu = alu_operation; end
            if (write_enable) begin o.we++; o.we_cyc = cyc; o.rd = regDest; o.mr = memOrReg; end
            if (pc_en) begin o.pc++; o.sel = pc_sel; end
            if (pc_en || halted) done = 1;
            @(posedge clk); #1;
        end
        inst_valid = 0; mem_ready = 0;
        chk("run_terminates", int'(done), 1);
        o.cycles = cyc; o.halted = halted; o.fault = fault;
    endtask

    task automatic cmp(input string nm, input res_t o, input res_t e);
        chk({nm, ".cycles"}, o.cycles, e.cycles);
        chk({nm, ".we"},     o.we,     e.we);
        chk({nm, ".we_cyc"}, o.we_cyc, e.we_cyc);
        chk({nm, ".pc_en"},  o.pc,     e.pc);
        chk({nm, ".pc_sel"}, o.sel,    e.sel);
        chk({nm, ".memreq"}, o.memc,   e.memc);
        chk({nm, ".memwe"},  o.memwe,  e.memwe);
        chk({nm, ".regDest"}, o.rd,    e.rd);
        chk({nm, ".memOrReg"}, o.mr,   e.mr);
        chk({nm, ".halted"}, o.halted, e.halted);
        chk({nm, ".fault"},  o.fault,  e.fault);
        if (e.chk_ex) begin
            chk({nm, ".aluSrc"}, o.as_, e.as_);
            chk({nm, ".aluop"},  o.alu, e.alu);
        end
    endtask

    task automatic do_reset();
        inst_valid = 0; mem_ready = 0;
        rst_b = 0; #1;
        chk("reset_outputs", int'({inst_req, mem_req, mem_we, regDest, aluSrc, memOrReg,
            write_enable, alu_operation, pc_en, pc_sel, halted, fault}), 0);
`ifdef MULTICYCLE_PERF_EN
        chk("reset_cycle_cnt", int'(cycle_cnt), 0);
        chk("reset_instret_cnt", int'(instret_cnt), 0);
`endif
        @(posedge clk); @(posedge clk); #2;
        rst_b = 1; #1;
        chk("inst_req_after_release", int'(inst_req), 1);
        @(posedge clk); #1;
    endtask

    task automatic halt_absorb();
        for (int k = 0; k < 4; k++) begin
            inst_valid = 1; mem_ready = 1;
            @(negedge clk);
            chk("halt_absorb", int'({halted, inst_req, mem_req, pc_en, write_enable}), 16);
            @(posedge clk); #1;
        end
        inst_valid = 0; mem_ready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_t o, e;
        logic [31:0] rnd, ri;
        logic [5:0] fns[7];
        logic [5:0] op, fn;
        int fw, mw;
        bit z;

        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        //            inst        fw mw z  cyc we sel memc h f
        tbl[0]  = '{32'h20010005, 0, 0, 0,  4, 1, 0, 0,  0, 0}; // addi $1,$0,5
        tbl[1]  = '{32'h8C220000, 0, 3, 0,  8, 1, 0, 4,  0, 0}; // lw, 3 stalls
        tbl[2]  = '{32'h10220003, 0, 0, 1,  3, 0, 1, 0,  0, 0}; // beq taken
        tbl[3]  = '{32'h10220003, 1, 0, 0,  4, 0, 0, 0,  0, 0}; // beq not taken
        tbl[4]  = '{32'hAC220000, 0, 20, 0, 19, 0, 0, 15, 1, 1}; // sw timeout
        tbl[5]  = '{32'hAC220000, 0, 14, 0, 18, 0, 0, 15, 0, 0}; // sw ready on 15th
        tbl[6]  = '{32'h0000000C, 0, 0, 0,  3, 0, 0, 0,  1, 0}; // syscall
        tbl[7]  = '{32'hFC000000, 0, 0, 0,  3, 0, 0, 0,  1, 1}; // opcode 0x3F
        tbl[8]  = '{32'h08000010, 0, 0, 0,  3, 0, 2, 0,  0, 0}; // j
        tbl[9]  = '{32'h00221820, 2, 0, 0,  6, 1, 0, 0,  0, 0}; // add, fetch stall
        tbl[10] = '{32'h00000001, 0, 0, 0,  3, 0, 0, 0,  1, 1}; // bad funct

        #1;
        do_reset();

        for (int v = 0; v < 11; v++) begin
            run(tbl[v].inst, tbl[v].fw, tbl[v].mw, tbl[v].z, o);
            chk($sformatf("tbl%0d.cycles", v), o.cycles, tbl[v].cycles);
            chk($sformatf("tbl%0d.we", v),     o.we,     tbl[v].we);
            chk($sformatf("tbl%0d.pc_sel", v), o.sel,    tbl[v].sel);
            chk($sformatf("tbl%0d.memreq", v), o.memc,   tbl[v].memc);
            chk($sformatf("tbl%0d.halted", v), o.halted, tbl[v].halted);
            chk($sformatf("tbl%0d.fault", v),  o.fault,  tbl[v].fault);
            e = model(tbl[v].inst, tbl[v].fw, tbl[v].mw, tbl[v].z);
            cmp($sformatf("tbl%0d", v), o, e);
            if (o.halted != 0) begin
                halt_absorb();
                do_reset();
            end
        end

        // Reset while a lw is stalled in MEM.
        inst = 32'h8C220000;
        for (int k = 0; k < 20 && !mem_req; k++) begin
            inst_valid = inst_req;
            @(negedge clk); @(posedge clk); #1;
        end
        inst_valid = 0; mem_ready = 0;
        chk("lw_reached_mem", int'(mem_req), 1);
        @(posedge clk); #2;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_reset_quiet", int'({write_enable, pc_en, inst_req}), 1);
            @(posedge clk); #1;
        end

        // Reset while waiting in FETCH.
        do_reset();

        for (int n = 0; n < 40; n++) begin
            rnd = $urandom();
            fn  = rnd[5:0];
            case ($urandom_range(0, 7))
                0: begin op = 6'h00; fn = fns[$urandom_range(0, 6)]; end
                1: op = 6'h08;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h02;
                6: begin op = 6'h00; fn = 6'h0C; end
                default: op = rnd[31:26];
            endcase
            ri = {op, rnd[25:6], fn};
            fw = $urandom_range(0, 3);
            mw = ($urandom_range(0, 4) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
            z  = $urandom_range(0, 1) == 1;
            run(ri, fw, mw, z, o);
            e = model(ri, fw, mw, z);
            cmp($sformatf("rnd%0d_%08h", n, ri), o, e);
            if (o.halted != 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
